// File: rtl/rr_req_collector.sv
// Request front end for the round-robin arbiter: one-entry slot per port,
// request vector to the arbiter, and a registered valid/ready output stage.
`timescale 1ns/1ps
module rr_req_collector #(
  parameter int NUM_PORT   = 6,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_PORT)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORT-1:0]              in_valid,
  input  logic [NUM_PORT*DATA_WIDTH-1:0]   in_data,
  output logic [NUM_PORT-1:0]              in_ready,
  output logic [NUM_PORT-1:0]              arb_req,
  input  logic [NUM_PORT-1:0]              arb_gnt,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [IDX_W-1:0]                 out_port,
  input  logic                             out_ready,
  output logic                             err_gnt
);

  localparam logic [NUM_PORT-1:0] ONE = NUM_PORT'(1);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  function automatic logic [NUM_PORT-1:0] lowest_bit(input logic [NUM_PORT-1:0] v);
    return v & (~v + ONE);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_PORT-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  state_t                  state;
  logic [NUM_PORT-1:0]     slot_vld;
  logic [DATA_WIDTH-1:0]   slot_data [NUM_PORT];

  logic                    load_en;
  logic [NUM_PORT-1:0]     slot_load;
  logic [NUM_PORT-1:0]     g;
  logic [NUM_PORT-1:0]     g_low;
  logic                    capture;
  logic                    grant_err;
  logic [DATA_WIDTH-1:0]   cap_data;

  assign out_valid = (state == FULL);
  assign in_ready  = ~slot_vld & {NUM_PORT{~rst}};
  assign slot_load = in_valid & in_ready;

  // Requests are withheld while the output stalls, so every grant can be absorbed.
  assign load_en   = ~out_valid | out_ready;
  assign arb_req   = load_en ? slot_vld : '0;

  assign g         = arb_gnt & arb_req;
  assign g_low     = lowest_bit(g);
  assign capture   = load_en & (|g);
  assign grant_err = (g != g_low) | (|(arb_gnt & ~arb_req));

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (g_low[i]) cap_data = cap_data | slot_data[i];
    end
  end

  // Slot payloads carry no reset; slot_vld qualifies them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORT; i++) begin
      if (slot_load[i]) slot_data[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Output stage: capture and drain share one edge for back-to-back transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      slot_vld <= '0;
      out_data <= '0;
      out_port <= '0;
      err_gnt  <= 1'b0;
    end else begin
      slot_vld <= (slot_vld & ~(capture ? g_low : '0)) | slot_load;
      if (grant_err) err_gnt <= 1'b1;
      if (capture) begin
        out_data <= cap_data;
        out_port <= onehot_idx(g_low);
      end
      case (state)
        EMPTY: if (capture) state <= FULL;
        FULL: begin
          if (capture)        state <= FULL;
          else if (out_ready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_collector.sv
// Directed bench for rr_req_collector with a behavioural round-robin arbiter
// and an output scoreboard.
`timescale 1ns/1ps
module tb_rr_req_collector;
  localparam int NP = 6;
  localparam int DW = 32;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     in_valid;
  logic [NP*DW-1:0]  in_data;
  logic [NP-1:0]     in_ready;
  logic [NP-1:0]     arb_req;
  logic [NP-1:0]     arb_gnt;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_port;
  logic              out_ready;
  logic              err_gnt;

  logic              force_en;
  logic [NP-1:0]     force_val;
  logic              ptr_clr;
  logic [2:0]        rr_ptr;
  logic [2:0]        rr_next;
  logic [NP-1:0]     rr_gnt;

  typedef struct packed {
    logic [IW-1:0] port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_req_collector #(.NUM_PORT(NP), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .arb_req(arb_req), .arb_gnt(arb_gnt),
    .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
    .out_ready(out_ready), .err_gnt(err_gnt)
  );

  // Rotating-priority arbiter model; a forced grant overrides it.
  always_comb begin
    rr_gnt  = '0;
    rr_next = rr_ptr;
    for (int k = 0; k < NP; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NP;
      if (rr_gnt == '0 && arb_req[idx]) begin
        rr_gnt[idx] = 1'b1;
        rr_next     = 3'((idx + 1) % NP);
      end
    end
  end

  assign arb_gnt = force_en ? force_val : rr_gnt;

  always_ff @(posedge clk) begin
    if (rst || ptr_clr)                  rr_ptr <= '0;
    else if (!force_en && rr_gnt != '0)  rr_ptr <= rr_next;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic post(input logic [NP-1:0] mask, input logic [DW-1:0] base, input bit push);
    exp_t e;
    in_valid = mask;
    for (int i = 0; i < NP; i++) begin
      if (mask[i]) begin
        in_data[i*DW +: DW] = base | DW'(i);
        if (push) begin
          e.port = IW'(i);
          e.data = base | DW'(i);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed_port=%0d expected=queued entry", out_port);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_port", 64'(out_port), 64'(e.port));
        check("sb_data", 64'(out_data), 64'(e.data));
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;
    force_en = 1'b0; force_val = '0; ptr_clr = 1'b0;
    tick; tick;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_arb_req",   64'(arb_req),   64'h0);
    check("rst_in_ready",  64'(in_ready),  64'h0);
    check("rst_err",       64'(err_gnt),   64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_port",  64'(out_port),  64'h0);
    rst = 1'b0; #1;
    check("rel_in_ready",  64'(in_ready),  64'h3f);

    // Single port
    out_ready = 1'b1;
    post(6'b000100, 32'hA5A5_0000, 1'b1);
    tick;
    in_valid = '0;
    check("t1_arb_req",   64'(arb_req),   64'h04);
    check("t1_in_ready",  64'(in_ready),  64'h3b);
    check("t1_early_vld", 64'(out_valid), 64'h0);
    tick;
    check("t1_out_valid", 64'(out_valid), 64'h1);
    check("t1_out_data",  64'(out_data),  64'hA5A5_0002);
    check("t1_out_port",  64'(out_port),  64'h2);
    check("t1_in_ready2", 64'(in_ready),  64'h3f);
    tick;
    check("t1_drained",   64'(out_valid), 64'h0);

    // All ports, round-robin from bit 0
    ptr_clr = 1'b1; tick; ptr_clr = 1'b0;
    post(6'b111111, 32'h3C00_0000, 1'b1);
    tick;
    in_valid = '0;
    for (int k = 0; k < NP; k++) begin
      tick;
      check("t2_out_valid", 64'(out_valid), 64'h1);
      check("t2_out_port",  64'(out_port),  64'(k));
    end
    check("t2_err", 64'(err_gnt), 64'h0);
    tick;
    check("t2_drained", 64'(out_valid), 64'h0);

    // Backpressure with ports 1 and 3 pending behind a held port 0
    out_ready = 1'b0;
    post(6'b000001, 32'h5000_0000, 1'b1);
    tick;
    post(6'b001010, 32'h5100_0000, 1'b1);
    tick;
    in_valid = '0;
    for (int k = 0; k < 5; k++) begin
      check("t3_arb_req",   64'(arb_req),             64'h0);
      check("t3_out_port",  64'(out_port),            64'h0);
      check("t3_out_data",  64'(out_data),            64'h5000_0000);
      check("t3_in_ready",  64'(in_ready & 6'b001010), 64'h0);
      tick;
    end
    out_ready = 1'b1; #1;
    check("t3_release_req", 64'(arb_req), 64'h0a);
    tick;
    check("t3_port1", 64'(out_port), 64'h1);
    tick;
    check("t3_port3", 64'(out_port), 64'h3);
    tick;
    check("t3_drained", 64'(out_valid), 64'h0);

    // Illegal multi-bit grant
    post(6'b001010, 32'h6000_0000, 1'b1);
    tick;
    in_valid = '0;
    force_val = 6'b001010; force_en = 1'b1; #1;
    check("t4_req",       64'(arb_req), 64'h0a);
    check("t4_err_pre",   64'(err_gnt), 64'h0);
    tick;
    force_en = 1'b0; #1;
    check("t4_port1",     64'(out_port),              64'h1);
    check("t4_data1",     64'(out_data),              64'h6000_0001);
    check("t4_err",       64'(err_gnt),               64'h1);
    check("t4_slot3_kept", 64'(in_ready & 6'b001000), 64'h0);
    check("t4_req3",      64'(arb_req),               64'h08);
    tick;
    check("t4_port3",     64'(out_port),  64'h3);
    check("t4_err_hold",  64'(err_gnt),   64'h1);
    tick;
    check("t4_drained",   64'(out_valid), 64'h0);
    check("t4_err_hold2", 64'(err_gnt),   64'h1);

    // Spurious grant with no request
    rst = 1'b1; tick; rst = 1'b0; #1;
    check("t5_err_clr",   64'(err_gnt),  64'h0);
    force_val = 6'b100000; force_en = 1'b1; #1;
    check("t5_req",       64'(arb_req),  64'h0);
    tick;
    force_en = 1'b0;
    check("t5_no_cap",    64'(out_valid), 64'h0);
    check("t5_err",       64'(err_gnt),   64'h1);
    check("t5_in_ready",  64'(in_ready),  64'h3f);
    tick; tick;
    check("t5_sticky",    64'(err_gnt),   64'h1);

    // Reset mid-stream: output full and four slots occupied
    out_ready = 1'b0;
    post(6'b000001, 32'h7000_0000, 1'b0);
    tick;
    post(6'b011110, 32'h7100_0000, 1'b0);
    tick;
    in_valid = '0;
    check("t6_full",      64'(out_valid), 64'h1);
    check("t6_slots",     64'(in_ready),  64'h21);
    rst = 1'b1;
    tick;
    check("t6_out_valid", 64'(out_valid), 64'h0);
    check("t6_arb_req",   64'(arb_req),   64'h0);
    check("t6_out_data",  64'(out_data),  64'h0);
    check("t6_out_port",  64'(out_port),  64'h0);
    check("t6_err",       64'(err_gnt),   64'h0);
    check("t6_in_rdy_rst", 64'(in_ready), 64'h0);
    rst = 1'b0; #1;
    check("t6_in_ready",  64'(in_ready),  64'h3f);
    tick;
    check("t6_idle_vld",  64'(out_valid), 64'h0);
    check("t6_idle_req",  64'(arb_req),   64'h0);

    check("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
